pe_tile_mac: RTL and testbench
==============================

Name: pe_tile_mac

Overview:
- Processing-element datapath that sits directly downstream of the per-PE 8x8 circular weight buffer.
- Each accepted input beat carries one activation scalar x[j]. The block pulses read_en to the buffer and consumes the buffer's 8 combinational lane outputs, which hold column j of the weight tile.
- It multiply-accumulates 8 rows in parallel over 8 beats, then presents an 8-element Q8.8 result vector with a valid/ready handshake.

Parameters:
- DW, 16, data width of weights, activations and outputs (signed two's complement).
- FRAC, 8, fractional bits (Q8.8). Product is Q16.16; result = accumulator >>> FRAC.
- BEATS, 8, beats per tile. Must equal the buffer SIZE.
- AW, 35, accumulator width (2*DW + log2(BEATS)); no internal overflow is possible.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  activation beat valid
- in_data  in  DW  activation x[j], signed Q8.8
- in_ready  out  1  block can accept a beat
- read_en  out  1  advance pulse to the weight buffer; equals in_valid & in_ready
- w_1..w_8  in  DW each  weight lanes from the buffer (row i, current column); combinational, sampled in the accept cycle
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts the result
- y_1..y_8  out  DW each  results, signed Q8.8, saturated
- beat_cnt  out  3  index of the next beat expected (0..BEATS-1)

Behaviour:
- Reset values (async, all immediately): state=S_ACC, beat_cnt=0, all accumulators=0, y_1..y_8=0, out_valid=0, in_ready=1, read_en=0.
- States:
  - S_ACC: in_ready=1, out_valid=0.
  - S_OUT: in_ready=0, out_valid=1, y_* held stable.
- Accept cycle = S_ACC & in_valid.
  - read_en=1 combinationally in that same cycle.
  - The buffer pointer advances at the next edge, so each read_en pulses exactly once per consumed column.
  - read_en is never asserted in S_OUT or while in_valid=0.
- Accumulate rule (per lane i, at the accept edge):
  - p_i = sign-extended w_i * in_data (2*DW bits).
  - If beat_cnt==0: acc_i <= p_i (implicit tile clear). Otherwise acc_i <= acc_i + p_i.
  - beat_cnt <= beat_cnt+1, wrapping BEATS-1 -> 0.
- Final beat (accept with beat_cnt==BEATS-1):
  - At the same edge, the full sums (acc_i + p_i) are scaled and saturated into y_i.
  - State goes to S_OUT. out_valid rises the cycle after the 8th accept, so latency from the last beat = 1 cycle.
- Scaling: r_i = (acc_i + p_i) >>> FRAC, arithmetic (floor), unless ROUND is enabled.
- Saturation: r_i > 32767 -> 0x7FFF; r_i < -32768 -> 0x8000; otherwise low DW bits.
- S_OUT behaviour:
  - Holds until out_ready=1, then returns to S_ACC at that edge with beat_cnt=0.
  - y_* retain their last values after the handshake.
  - out_ready while in S_ACC is ignored.
- No same-cycle bypass: a beat offered in the handshake cycle is not accepted (in_ready=0); it is accepted the next cycle.
- Gaps: in_valid low mid-tile stalls the block; beat_cnt and acc hold and read_en=0.
- Reset mid-tile: the partial tile is discarded. This block and the buffer share rst, so both pointers return to 0 together.

Optional Feature:
- Macro PE_TILE_ROUND_EN.
- Defined: round-half-up. r_i = (sum + 2^(FRAC-1)) >>> FRAC, computed at AW+1 bits, then saturated.
- Undefined: truncation toward minus infinity (plain arithmetic shift). No extra adder is synthesised.

Test Plan:
- Identity sum: all w=0x0100, x=0x0100 for 8 beats -> read_en pulses 8 times; out_valid 1 cycle after beat 8; all y=0x0800.
- Sign: w=0xFF00 (-1.0) on all lanes, x=0x0200 -> all y=0xF000 (-16.0). Lane 3 w=0x0080 with others as above -> y_3=0x0800.
- Saturation: all w=0x7FFF, x=0x7FFF -> all y=0x7FFF. w=0x8000, x=0x7FFF -> all y=0x8000.
- Rounding: w_1=0x0001 at beat 0 only, x=0x0080, all other products 0 -> y_1=0x0001 with PE_TILE_ROUND_EN, 0x0000 without.
- Backpressure and stalls: in_valid toggled 1/0 across beats, then out_ready held low 5 cycles:
  - in_ready=0 and read_en=0 throughout S_OUT.
  - y stable while held.
  - A second tile after the handshake is computed correctly from cleared accumulators.
- Reset mid-tile: assert rst after beat 3 -> y=0, out_valid=0, beat_cnt=0 immediately. A following full tile of 0x0100 x 0x0100 yields 0x0800.

Source files
------------

// File: rtl/pe_tile_mac_if.sv
// Handshake and lane bundle between the PE datapath, its activation source,
// the weight buffer and the result consumer.
interface pe_tile_mac_if #(parameter int DW = 16);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 read_en;
    logic signed [DW-1:0] w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y_1, y_2, y_3, y_4, y_5, y_6, y_7, y_8;
    logic [2:0]           beat_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        output w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8,
        input  in_ready, read_en, out_valid, beat_cnt,
        input  y_1, y_2, y_3, y_4, y_5, y_6, y_7, y_8
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8,
        output in_ready, read_en, out_valid, beat_cnt,
        output y_1, y_2, y_3, y_4, y_5, y_6, y_7, y_8
    );
endinterface

// File: rtl/pe_tile_mac.sv
// 8-row Q8.8 multiply-accumulate over an 8-beat tile; PE_TILE_ROUND_EN selects round-half-up.
// Latency: result vector valid 1 cycle after the last accepted beat.
// Backpressure: in_ready drops while the result waits for out_ready; gaps on in_valid stall.
module pe_tile_mac #(
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int BEATS = 8,
    parameter int AW    = 35
) (
    input  logic          clk,
    input  logic          rst,
    pe_tile_mac_if.slave  bus
);
    localparam int LANES = 8;
    localparam int CW    = $clog2(BEATS);

    localparam logic signed [AW:0] MAXV = (AW+1)'(2**(DW-1) - 1);
    localparam logic signed [AW:0] MINV = (AW+1)'(-(2**(DW-1)));
`ifdef PE_TILE_ROUND_EN
    localparam logic signed [AW:0] HALF = (AW+1)'(2**(FRAC-1));
`endif

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic signed [AW-1:0] acc   [LANES];
    logic signed [DW-1:0] y_q   [LANES];
    logic signed [DW-1:0] w     [LANES];
    logic signed [2*DW-1:0] prod [LANES];
    logic signed [AW-1:0] sum   [LANES];
    logic                 accept;
    logic                 last_beat;

    function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW:0] s);
        logic signed [AW:0] r;
`ifdef PE_TILE_ROUND_EN
        r = (s + HALF) >>> FRAC;
`else
        r = s >>> FRAC;
`endif
        if (r > MAXV)
            return {1'b0, {(DW-1){1'b1}}};
        else if (r < MINV)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return r[DW-1:0];
    endfunction

    assign w = '{bus.w_1, bus.w_2, bus.w_3, bus.w_4, bus.w_5, bus.w_6, bus.w_7, bus.w_8};

    assign accept    = bus.in_valid & in_ready_q;
    assign last_beat = (cnt == CW'(BEATS - 1));

    // Beat 0 starts from zero rather than the stale accumulator: implicit tile clear.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic signed [AW-1:0] base;
            base    = (cnt == '0) ? {AW{1'b0}} : acc[i];
            prod[i] = (2*DW)'(w[i]) * (2*DW)'(bus.in_data);
            sum[i]  = base + AW'(prod[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_ACC;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            case (state)
                S_ACC: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < LANES; i++)
                            acc[i] <= sum[i];
                        if (last_beat) begin
                            cnt         <= '0;
                            state       <= S_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < LANES; i++)
                                y_q[i] <= scale_sat((AW+1)'(sum[i]));
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        state       <= S_ACC;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.read_en   = accept;
    assign bus.out_valid = out_valid_q;
    assign bus.beat_cnt  = cnt;
    assign bus.y_1 = y_q[0];
    assign bus.y_2 = y_q[1];
    assign bus.y_3 = y_q[2];
    assign bus.y_4 = y_q[3];
    assign bus.y_5 = y_q[4];
    assign bus.y_6 = y_q[5];
    assign bus.y_7 = y_q[6];
    assign bus.y_8 = y_q[7];
endmodule

// File: tb/tb_pe_tile_mac.sv
// Randomised tiles against a plain-arithmetic dot-product model of the PE tile MAC.
module tb_pe_tile_mac;
    logic clk = 1'b0;
    logic rst;

    pe_tile_mac_if #(.DW(16)) bus();

    pe_tile_mac dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_seen = 0;
    int exp_rd = 0;

    logic signed [15:0] tw [8][8];   // [lane][beat]
    logic signed [15:0] tx [8];

    always @(negedge clk) if (bus.read_en === 1'b1) rd_seen++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_y(input int lane);
        longint s = 0;
        longint r;
        for (int j = 0; j < 8; j++)
            s += longint'(tw[lane][j]) * longint'(tx[j]);
`ifdef PE_TILE_ROUND_EN
        r = (s + 128) >>> 8;
`else
        r = s >>> 8;
`endif
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [15:0] get_y(input int i);
        case (i)
            0: return bus.y_1;
            1: return bus.y_2;
            2: return bus.y_3;
            3: return bus.y_4;
            4: return bus.y_5;
            5: return bus.y_6;
            6: return bus.y_7;
            default: return bus.y_8;
        endcase
    endfunction

    task automatic set_col(input int j);
        bus.w_1 = tw[0][j]; bus.w_2 = tw[1][j]; bus.w_3 = tw[2][j]; bus.w_4 = tw[3][j];
        bus.w_5 = tw[4][j]; bus.w_6 = tw[5][j]; bus.w_7 = tw[6][j]; bus.w_8 = tw[7][j];
    endtask

    task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
        for (int i = 0; i < 8; i++) begin
            tx[i] = xv;
            for (int j = 0; j < 8; j++) tw[i][j] = wv;
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic run_tile(input int nb, input int gap_pct, input int hold);
        logic [15:0] exp_y [8];
        for (int i = 0; i < 8; i++) exp_y[i] = ref_y(i);
        for (int j = 0; j < nb; j++) begin
            int g = 0;
            while (g < 4 && $urandom_range(99) < gap_pct) begin
                bus.in_valid  = 1'b0;
                bus.in_data   = 16'($urandom);
                bus.out_ready = 1'($urandom_range(1));
                @(negedge clk);
                check("gap_read_en", bus.read_en, 0);
                check("gap_beat_cnt", bus.beat_cnt, j);
                @(posedge clk); #1;
                g++;
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = tx[j];
            bus.out_ready = 1'($urandom_range(1));
            set_col(j);
            @(negedge clk);
            check("beat_cnt", bus.beat_cnt, j);
            check("read_en", bus.read_en, 1);
            check("in_ready_acc", bus.in_ready, 1);
            check("out_valid_acc", bus.out_valid, 0);
            @(posedge clk); #1;
            exp_rd++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (nb < 8) return;
        for (int k = 0; k <= hold; k++) begin
            bus.in_valid  = 1'($urandom_range(1));
            bus.in_data   = 16'($urandom);
            bus.out_ready = (k == hold);
            @(negedge clk);
            check("out_valid", bus.out_valid, 1);
            check("in_ready_out", bus.in_ready, 0);
            check("read_en_out", bus.read_en, 0);
            for (int i = 0; i < 8; i++) check($sformatf("y_%0d", i + 1), get_y(i), exp_y[i]);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("out_valid_after", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
        check("beat_cnt_after", bus.beat_cnt, 0);
        for (int i = 0; i < 8; i++) check($sformatf("y_keep_%0d", i + 1), get_y(i), exp_y[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        fill(16'h0000, 16'h0000);
        set_col(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_beat_cnt", bus.beat_cnt, 0);
        check("rst_read_en", bus.read_en, 0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_y_%0d", i + 1), get_y(i), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill(16'h0100, 16'h0100); run_tile(8, 0, 0);           // identity -> 0x0800
        fill(16'hFF00, 16'h0200); run_tile(8, 0, 1);           // -16.0
        for (int j = 0; j < 8; j++) tw[2][j] = 16'h0080;
        run_tile(8, 0, 0);                                     // lane 3 -> 0x0800
        fill(16'h7FFF, 16'h7FFF); run_tile(8, 0, 0);           // +sat
        fill(16'h8000, 16'h7FFF); run_tile(8, 0, 0);           // -sat
        fill(16'h0000, 16'h0080); tw[0][0] = 16'h0001;
        run_tile(8, 0, 0);                                     // rounding
        fill(16'h0100, 16'h0100);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) tw[i][j] = 16'(int'($urandom_range(2047)) - 1024);
        run_tile(8, 50, 5);                                    // stalls + backpressure
        fill(16'h0100, 16'h0100); run_tile(8, 0, 0);

        run_tile(3, 0, 0);                                     // reset mid-tile
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_beat_cnt", bus.beat_cnt, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) check($sformatf("mid_rst_y_%0d", i + 1), get_y(i), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_tile(8, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) begin
                tx[i] = (t % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(2047)) - 1024);
                for (int j = 0; j < 8; j++)
                    tw[i][j] = (t % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(2047)) - 1024);
            end
            run_tile(8, 30, $urandom_range(3));
        end

        check("read_en_pulses", 64'(rd_seen), 64'(exp_rd));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
